decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of bundle entries; power of two, >= 2.
REQ-002 SHALL have parameter PAYLOAD_W, default 256, width of one packed decoded bundle (ins0/ins1 fields, bundle PC, BTB info).
REQ-003 SHALL have port core_clock_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port core_reset_i, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port core_flush_i, input, 1: pipeline flush (redirect); discards all held bundles.
REQ-006 SHALL have port enq_valid_i, input, 1: decode stage presents a bundle.
REQ-007 SHALL have port enq_payload_i, input, PAYLOAD_W: bundle from decode.
REQ-008 SHALL have port enq_busy_o, output, 1: queue cannot accept; drives the decode stage's busy input.
REQ-009 SHALL have port deq_valid_o, output, 1: head bundle available to rename.
REQ-010 SHALL have port deq_payload_o, output, PAYLOAD_W: head bundle.
REQ-011 SHALL have port deq_busy_i, input, 1: rename stalled; head is not consumed.
REQ-012 SHALL have port occupancy_o, output, $clog2(DEPTH)+1: entries currently held.
REQ-013 SHALL have port full_cycles_o, output, 16: saturating count of cycles with enq_valid_i=1 and enq_busy_o=1.

Function
REQ-014 SHALL accept an enqueue when enq_valid_i=1 and enq_busy_o=0 and core_flush_i=0: payload written at tail, tail pointer +1.
REQ-015 SHALL perform a dequeue when deq_valid_o=1 and deq_busy_i=0 and core_flush_i=0: head pointer +1.
REQ-016 SHALL wrap head and tail pointers modulo DEPTH; full/empty are distinguished by occupancy, not by pointer equality.
REQ-017 SHALL drive enq_busy_o = (occupancy_o == DEPTH), from registered state only; no combinational path from deq_busy_i.
REQ-018 SHALL drive deq_valid_o = (occupancy_o != 0); deq_payload_o = storage[head]; no combinational path from enq_* to deq_*.
REQ-019 SHALL provide 1-cycle latency: bundle accepted in cycle N is presented at the head in cycle N+1 at the earliest.
REQ-020 SHALL, on simultaneous accepted enqueue and dequeue, leave occupancy unchanged and update both pointers.
REQ-021 SHALL update occupancy +1 on enqueue only, -1 on dequeue only; never exceed DEPTH nor go below 0.
REQ-022 SHALL hold deq_payload_o stable while deq_valid_o=1 and deq_busy_i=1.
REQ-023 SHALL, on core_flush_i=1, set head, tail, occupancy to 0 next cycle; same-cycle enqueue and dequeue are ignored; full_cycles_o is unaffected.
REQ-024 SHALL increment full_cycles_o when enq_valid_i=1 and enq_busy_o=1, saturating at 16'hFFFF.
REQ-025 SHALL not require storage contents to be reset; only pointers, occupancy, counter are reset.

Reset
REQ-026 SHALL, while core_reset_i=0 at a clock edge, set head=0, tail=0, occupancy_o=0, full_cycles_o=0; hence deq_valid_o=0, enq_busy_o=0.
REQ-027 SHALL give reset priority over flush, enqueue and dequeue, including reset asserted mid-stream with a full queue.
REQ-028 SHALL accept an enqueue in the first cycle after core_reset_i returns to 1.

Verification (DEPTH=4, PAYLOAD_W=8)
REQ-029 SHALL cover fill: enqueue 0x11,0x22,0x33,0x44 with deq_busy_i=1 -> occupancy_o=4, enq_busy_o=1; a fifth enq_valid_i held 3 cycles -> not accepted, full_cycles_o=3.
REQ-030 SHALL cover drain order: from full, deq_busy_i=0 for 4 cycles -> deq_payload_o 0x11,0x22,0x33,0x44 in order, then deq_valid_o=0, occupancy_o=0.
REQ-031 SHALL cover streaming wrap-around: continuous enq and deq for 10 bundles 0x01..0x0A -> each appears one cycle after enqueue, occupancy_o stays 1, pointers wrap with no loss.
REQ-032 SHALL cover flush: occupancy_o=3 with core_flush_i=1 and enq_valid_i=1 same cycle -> next cycle occupancy_o=0, deq_valid_o=0, enqueued bundle discarded.
REQ-033 SHALL cover reset mid-operation: full queue, full_cycles_o=5, core_reset_i=0 for one cycle -> occupancy_o=0, full_cycles_o=0, enq_busy_o=0; enqueue 0x5A next cycle -> head 0x5A one cycle later.
REQ-034 SHALL cover saturation: hold full with enq_valid_i=1 for 65540 cycles -> full_cycles_o=16'hFFFF, no wrap.

Source files
------------

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : decode_queue
// Description : Circular buffer of decoded bundles between decode and rename.
//               One-cycle latency, flush discards held bundles, saturating
//               count of cycles in which decode was stalled by a full queue.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_queue #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 256
) (
    input  logic                       core_clock_i,
    input  logic                       core_reset_i,
    input  logic                       core_flush_i,
    input  logic                       enq_valid_i,
    input  logic [PAYLOAD_W-1:0]       enq_payload_i,
    output logic                       enq_busy_o,
    output logic                       deq_valid_o,
    output logic [PAYLOAD_W-1:0]       deq_payload_o,
    input  logic                       deq_busy_i,
    output logic [$clog2(DEPTH):0]     occupancy_o,
    output logic [15:0]                full_cycles_o
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_OCC_W = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_FULL  = c_OCC_W'(DEPTH);

    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_OCC_W-1:0]   r_occ;
    logic [15:0]          r_full_cycles;

    logic w_enq;
    logic w_deq;
    logic w_stall;

    // Status outputs derive only from registered occupancy, so neither
    // handshake input can reach the opposite side combinationally.
    assign enq_busy_o    = (r_occ == c_FULL);
    assign deq_valid_o   = (r_occ != '0);
    assign deq_payload_o = r_mem[r_head];
    assign occupancy_o   = r_occ;
    assign full_cycles_o = r_full_cycles;

    assign w_enq   = enq_valid_i & ~enq_busy_o & ~core_flush_i;
    assign w_deq   = deq_valid_o & ~deq_busy_i & ~core_flush_i;
    assign w_stall = enq_valid_i & enq_busy_o;

    // Bundle storage; contents are don't-care until written, so no reset.
    always_ff @(posedge core_clock_i) begin
        if (w_enq) begin
            r_mem[r_tail] <= enq_payload_i;
        end
    end

    // Pointers and occupancy; reset beats flush, flush beats handshakes.
    always_ff @(posedge core_clock_i) begin
        if (!core_reset_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (core_flush_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            if (w_enq && !w_deq) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_deq && !w_enq) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

    // Saturating stall counter; a flush does not clear it.
    always_ff @(posedge core_clock_i) begin
        if (!core_reset_i) begin
            r_full_cycles <= '0;
        end else if (w_stall && (r_full_cycles != 16'hFFFF)) begin
            r_full_cycles <= r_full_cycles + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_queue
// Description : Self-checking bench for decode_queue (DEPTH=4, PAYLOAD_W=8)
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_queue;

    localparam int c_DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       enq_valid;
    logic [7:0] enq_payload;
    logic       enq_busy;
    logic       deq_valid;
    logic [7:0] deq_payload;
    logic       deq_busy;
    logic [2:0] occupancy;
    logic [15:0] full_cycles;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents and stall counter
    logic [7:0] m_q[$];
    int         m_cnt = 0;

    always #5 clk = ~clk;

    decode_queue #(
        .DEPTH     (c_DEPTH),
        .PAYLOAD_W (8)
    ) dut (
        .core_clock_i  (clk),
        .core_reset_i  (rst_n),
        .core_flush_i  (flush),
        .enq_valid_i   (enq_valid),
        .enq_payload_i (enq_payload),
        .enq_busy_o    (enq_busy),
        .deq_valid_o   (deq_valid),
        .deq_payload_o (deq_payload),
        .deq_busy_i    (deq_busy),
        .occupancy_o   (occupancy),
        .full_cycles_o (full_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs seen at the edge,
    // then compare every observable output.
    task automatic cycle();
        logic       s_rst, s_flush, s_ev, s_db;
        logic [7:0] s_pl;
        bit         m_full, m_nonempty;
        s_rst = rst_n; s_flush = flush; s_ev = enq_valid; s_db = deq_busy; s_pl = enq_payload;
        m_full     = (m_q.size() == c_DEPTH);
        m_nonempty = (m_q.size() != 0);
        @(posedge clk);
        #1;
        if (!s_rst) begin
            m_q.delete();
            m_cnt = 0;
        end else begin
            if (s_ev && m_full && m_cnt < 65535) m_cnt++;
            if (s_flush) begin
                m_q.delete();
            end else begin
                if (m_nonempty && !s_db) void'(m_q.pop_front());
                if (s_ev && !m_full) m_q.push_back(s_pl);
            end
        end
        chk("occupancy",   32'(occupancy),   32'(m_q.size()));
        chk("enq_busy",    32'(enq_busy),    32'(m_q.size() == c_DEPTH));
        chk("deq_valid",   32'(deq_valid),   32'(m_q.size() != 0));
        chk("full_cycles", 32'(full_cycles), 32'(m_cnt));
        if (m_q.size() != 0) chk("head", 32'(deq_payload), 32'(m_q[0]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_busy = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic fill4();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        deq_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_valid = 1'b1; enq_payload = vals[i];
            cycle();
        end
    endtask

    initial begin
        logic [7:0] exp_drain [4];
        exp_drain = '{8'h11, 8'h22, 8'h33, 8'h44};
        rst_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_payload = '0; deq_busy = 1'b0;

        // Reset state
        do_reset();
        chk("rst_occ",  32'(occupancy), 0);
        chk("rst_busy", 32'(enq_busy),  0);
        chk("rst_valid",32'(deq_valid), 0);
        chk("rst_full", 32'(full_cycles), 0);

        // Fill, then a fifth bundle held three cycles
        fill4();
        enq_payload = 8'h55;
        for (int i = 0; i < 3; i++) cycle();
        enq_valid = 1'b0;
        chk("fill_occ",  32'(occupancy),   4);
        chk("fill_busy", 32'(enq_busy),    1);
        chk("fill_full", 32'(full_cycles), 3);

        // Drain in order
        deq_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 32'(deq_payload), 32'(exp_drain[i]));
            cycle();
        end
        chk("drain_valid", 32'(deq_valid), 0);
        chk("drain_occ",   32'(occupancy), 0);

        // Streaming across pointer wrap
        enq_valid = 1'b1; deq_busy = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            enq_payload = 8'(k);
            cycle();
            chk("stream_head", 32'(deq_payload), k);
            chk("stream_occ",  32'(occupancy),   1);
        end
        enq_valid = 1'b0;
        cycle();
        chk("stream_empty", 32'(deq_valid), 0);

        // Flush with a simultaneous enqueue
        deq_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_valid = 1'b1; enq_payload = 8'(8'hA0 + i);
            cycle();
        end
        chk("preflush_occ", 32'(occupancy), 3);
        flush = 1'b1; enq_valid = 1'b1; enq_payload = 8'h77;
        cycle();
        flush = 1'b0; enq_valid = 1'b0;
        chk("flush_occ",   32'(occupancy), 0);
        chk("flush_valid", 32'(deq_valid), 0);
        cycle();
        chk("flush_discard", 32'(occupancy), 0);

        // Reset mid-operation from full with a stall count of 5
        do_reset();
        fill4();
        enq_payload = 8'h66;
        for (int i = 0; i < 5; i++) cycle();
        chk("pre_rst_full", 32'(full_cycles), 5);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mid_rst_occ",  32'(occupancy),   0);
        chk("mid_rst_full", 32'(full_cycles), 0);
        chk("mid_rst_busy", 32'(enq_busy),    0);
        enq_valid = 1'b1; enq_payload = 8'h5A;
        cycle();
        enq_valid = 1'b0;
        chk("post_rst_valid", 32'(deq_valid),   1);
        chk("post_rst_head",  32'(deq_payload), 32'h5A);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            enq_valid   = ($urandom_range(0, 9) < 6);
            deq_busy    = ($urandom_range(0, 9) < 4);
            enq_payload = 8'($urandom);
            cycle();
        end
        rst_n = 1'b1; flush = 1'b0;

        // Counter saturation
        do_reset();
        fill4();
        enq_valid = 1'b1; enq_payload = 8'h99;
        for (int i = 0; i < 65540; i++) cycle();
        chk("sat_full", 32'(full_cycles), 32'hFFFF);
        enq_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
